// File: rtl/math_adder_pkg.sv
// Shared types and Brent-Kung prefix cells for the pipelined add/subtract unit.
// Prefix position 0 carries the carry-in; positions 1..16 are operand bits 0..15.
package math_adder_pkg;

    localparam int N16 = 16;

    typedef struct packed {
        logic g;
        logic p;
    } pg_t;

    // S1 payload: bit 0 of p/g is the carry-in, which also encodes the subtract flag.
    typedef struct packed {
        logic           a_msb;
        logic           bm_msb;
        logic [N16:0]   p;
        logic [N16:0]   g;
    } s1_t;

    // S2 payload: up-sweep results (resolved G at 1,3,7,15 plus spans the down-sweep needs).
    typedef struct packed {
        logic           a_msb;
        logic           bm_msb;
        logic           sub;
        logic [N16:1]   p_hi;
        logic [8:0]     g_even;
        logic           g1;
        logic           g3;
        logic           g7;
        logic           g15;
        pg_t            pg54;
        pg_t            pg98;
        pg_t            pg1312;
        pg_t            pg118;
    } s2_t;

    typedef struct packed {
        logic [N16-1:0] sum;
        logic           carry;
        logic           borrow;
        logic           ovf;
        logic           zero;
    } s3_t;

    function automatic pg_t mk_pg(input logic g, input logic p);
        pg_t r;
        r.g = g;
        r.p = p;
        return r;
    endfunction

    function automatic pg_t bk_black(input pg_t pg_hi, input pg_t pg_lo);
        pg_t r;
        r.g = pg_hi.g | (pg_hi.p & pg_lo.g);
        r.p = pg_hi.p & pg_lo.p;
        return r;
    endfunction

    function automatic logic bk_gray(input pg_t pg_hi, input logic g_lo);
        return pg_hi.g | (pg_hi.p & g_lo);
    endfunction

endpackage

// File: rtl/math_addsub_pipe_stage.sv
// Generic valid/ready register slice; one payload register plus a valid flag.
module math_addsub_pipe_stage #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_data,
    output logic         dn_valid,
    input  logic         dn_ready,
    output logic [W-1:0] dn_data
);

    // Handshake: a transfer happens on a clock edge where valid and ready are both
    // high; data is held stable while valid is high and ready is low; ready never
    // waits on valid, and flush drops everything held without capturing the input.
    logic advance;

    assign advance  = !dn_valid || dn_ready;
    assign up_ready = advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
        end else if (flush) begin
            dn_valid <= 1'b0;
        end else if (advance) begin
            dn_valid <= up_valid;
            if (up_valid) begin
                dn_data <= up_data;
            end
        end
    end

endmodule

// File: rtl/math_addsub_brent_kung_pipe_016.sv
// Three-stage 16-bit add/subtract: operand prep, Brent-Kung up-sweep, down-sweep + flags.
module math_addsub_brent_kung_pipe_016
    import math_adder_pkg::*;
#(
    parameter int N = N16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_flush,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_sub,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_sum,
    output logic         o_carry,
    output logic         o_borrow,
    output logic         o_ovf,
    output logic         o_zero
);

    if (N != N16) begin : g_bad_width
        $error("math_addsub_brent_kung_pipe_016: prefix tree is fixed at 16 bits");
    end

    logic [N-1:0] bm;
    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    s3_t s3_d, s3_q;
    logic r1, r2, r3, v1, v2;

    // Stage 1: invert B for subtract and inject carry-in at prefix position 0.
    assign bm = i_b ^ {N{i_sub}};

    always_comb begin
        s1_d.a_msb  = i_a[N-1];
        s1_d.bm_msb = bm[N-1];
        s1_d.p      = {i_a ^ bm, i_sub};
        s1_d.g      = {i_a & bm, i_sub};
    end

    // Stage 2: up-sweep over spans of 2, 4, 8 and 16.
    pg_t b32, b54, b76, b98, b1110, b1312, b1514;
    pg_t b74, b118, b1512, b158;
    logic gg1, gg3, gg7, gg15;

    always_comb begin
        gg1   = bk_gray(mk_pg(s1_q.g[1], s1_q.p[1]), s1_q.g[0]);
        b32   = bk_black(mk_pg(s1_q.g[3],  s1_q.p[3]),  mk_pg(s1_q.g[2],  s1_q.p[2]));
        b54   = bk_black(mk_pg(s1_q.g[5],  s1_q.p[5]),  mk_pg(s1_q.g[4],  s1_q.p[4]));
        b76   = bk_black(mk_pg(s1_q.g[7],  s1_q.p[7]),  mk_pg(s1_q.g[6],  s1_q.p[6]));
        b98   = bk_black(mk_pg(s1_q.g[9],  s1_q.p[9]),  mk_pg(s1_q.g[8],  s1_q.p[8]));
        b1110 = bk_black(mk_pg(s1_q.g[11], s1_q.p[11]), mk_pg(s1_q.g[10], s1_q.p[10]));
        b1312 = bk_black(mk_pg(s1_q.g[13], s1_q.p[13]), mk_pg(s1_q.g[12], s1_q.p[12]));
        b1514 = bk_black(mk_pg(s1_q.g[15], s1_q.p[15]), mk_pg(s1_q.g[14], s1_q.p[14]));
        gg3   = bk_gray(b32, gg1);
        b74   = bk_black(b76, b54);
        b118  = bk_black(b1110, b98);
        b1512 = bk_black(b1514, b1312);
        gg7   = bk_gray(b74, gg3);
        b158  = bk_black(b1512, b118);
        gg15  = bk_gray(b158, gg7);

        s2_d.a_msb  = s1_q.a_msb;
        s2_d.bm_msb = s1_q.bm_msb;
        s2_d.sub    = s1_q.p[0];
        s2_d.p_hi   = s1_q.p[N16:1];
        for (int i = 0; i <= 8; i++) begin
            s2_d.g_even[i] = s1_q.g[2*i];
        end
        s2_d.g1     = gg1;
        s2_d.g3     = gg3;
        s2_d.g7     = gg7;
        s2_d.g15    = gg15;
        s2_d.pg54   = b54;
        s2_d.pg98   = b98;
        s2_d.pg1312 = b1312;
        s2_d.pg118  = b118;
    end

    // Stage 3: down-sweep; c[i] is the group generate from position i down to 0.
    logic [N16:0]   c;
    logic [N16-1:0] sum;

    always_comb begin
        c      = '0;
        c[0]   = s2_q.g_even[0];
        c[1]   = s2_q.g1;
        c[3]   = s2_q.g3;
        c[7]   = s2_q.g7;
        c[15]  = s2_q.g15;
        c[11]  = bk_gray(s2_q.pg118, c[7]);
        c[5]   = bk_gray(s2_q.pg54, c[3]);
        c[9]   = bk_gray(s2_q.pg98, c[7]);
        c[13]  = bk_gray(s2_q.pg1312, c[11]);
        for (int i = 2; i <= N16; i += 2) begin
            c[i] = bk_gray(mk_pg(s2_q.g_even[i/2], s2_q.p_hi[i]), c[i-1]);
        end
        sum = s2_q.p_hi ^ c[N16-1:0];

        s3_d.sum    = sum;
        s3_d.carry  = c[N16];
        s3_d.borrow = s2_q.sub & ~c[N16];
        // Same-sign operands whose result sign differs: equals carry-in ^ carry-out of the MSB.
        s3_d.ovf    = (s2_q.a_msb ~^ s2_q.bm_msb) & (sum[N16-1] ^ s2_q.a_msb);
        s3_d.zero   = ~|sum;
    end

    math_addsub_pipe_stage #(.W($bits(s1_t))) u_stage1 (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .flush    (i_flush),
        .up_valid (i_valid),
        .up_ready (r1),
        .up_data  (s1_d),
        .dn_valid (v1),
        .dn_ready (r2),
        .dn_data  (s1_q)
    );

    math_addsub_pipe_stage #(.W($bits(s2_t))) u_stage2 (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .flush    (i_flush),
        .up_valid (v1),
        .up_ready (r2),
        .up_data  (s2_d),
        .dn_valid (v2),
        .dn_ready (r3),
        .dn_data  (s2_q)
    );

    math_addsub_pipe_stage #(.W($bits(s3_t))) u_stage3 (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .flush    (i_flush),
        .up_valid (v2),
        .up_ready (r3),
        .up_data  (s3_d),
        .dn_valid (o_valid),
        .dn_ready (i_ready),
        .dn_data  (s3_q)
    );

    // Held low while reset is asserted so every output reads 0 in reset.
    assign o_ready  = i_rst_n & r1;
    assign o_sum    = s3_q.sum;
    assign o_carry  = s3_q.carry;
    assign o_borrow = s3_q.borrow;
    assign o_ovf    = s3_q.ovf;
    assign o_zero   = s3_q.zero;

endmodule

// File: tb/tb_math_addsub_brent_kung_pipe_016.sv
// Self-checking bench: directed vector table, backpressure/flush/reset sequences, random stream.
module tb_math_addsub_brent_kung_pipe_016;

    logic        clk;
    logic        rst_n;
    logic        i_flush;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] i_a;
    logic [15:0] i_b;
    logic        i_sub;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] o_sum;
    logic        o_carry;
    logic        o_borrow;
    logic        o_ovf;
    logic        o_zero;

    logic [19:0] got;
    assign got = {o_sum, o_carry, o_borrow, o_ovf, o_zero};

    int pass_cnt = 0;
    int chk_cnt  = 0;
    logic [19:0] exp_q[$];
    logic        hold_pending;
    logic [19:0] hold_val;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [19:0] exp;
    } vec_t;
    vec_t vecs[10];

    logic [15:0] bp_a[5];
    logic [15:0] bp_b[5];
    logic        bp_s[5];

    math_addsub_brent_kung_pipe_016 dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_flush  (i_flush),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_sub    (i_sub),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_sum    (o_sum),
        .o_carry  (o_carry),
        .o_borrow (o_borrow),
        .o_ovf    (o_ovf),
        .o_zero   (o_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: integer arithmetic on unsigned and signed interpretations.
    function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
        int ua, ub, sa, sb, ur, sr;
        logic [15:0] sum;
        logic c, ov;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (s) begin
            ur = ua - ub;
            sr = sa - sb;
            c  = (ua >= ub);
        end else begin
            ur = ua + ub;
            sr = sa + sb;
            c  = (ur > 65535);
        end
        sum = ur[15:0];
        ov  = (sr > 32767) || (sr < -32768);
        return {sum, c, s & !c, ov, sum == 16'h0000};
    endfunction

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                          input logic [19:0] exp);
        @(posedge clk); #1;
        i_valid = 1'b1; i_a = a; i_b = b; i_sub = s; i_ready = 1'b1;
        @(negedge clk);
        check("accept_ready", 32'(o_ready), 32'd1);
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(negedge clk);
        check("latency_c1", 32'(o_valid), 32'd0);
        @(negedge clk);
        check("latency_c2", 32'(o_valid), 32'd0);
        @(negedge clk);
        check("latency_c3", 32'(o_valid), 32'd1);
        check("vector_result", 32'(got), 32'(exp));
    endtask

    task automatic sb_step();
        if (hold_pending) check("hold_stable", 32'(got), 32'(hold_val));
        hold_pending = o_valid && !i_ready;
        hold_val     = got;
        if (o_valid && i_ready) begin
            if (exp_q.size() == 0) check("unexpected_output", 32'd1, 32'd0);
            else check("stream_result", 32'(got), 32'(exp_q.pop_front()));
        end
        if (i_valid && o_ready) exp_q.push_back(model(i_a, i_b, i_sub));
    endtask

    initial begin
        int acc;
        int seen;
        vecs[0] = '{16'h0005, 16'h0003, 1'b1, {16'h0002, 1'b1, 1'b0, 1'b0, 1'b0}};
        vecs[1] = '{16'h0003, 16'h0005, 1'b1, {16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b0}};
        vecs[2] = '{16'h8000, 16'h0001, 1'b1, {16'h7FFF, 1'b1, 1'b0, 1'b1, 1'b0}};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, {16'h8000, 1'b0, 1'b0, 1'b1, 1'b0}};
        vecs[4] = '{16'hFFFF, 16'h0001, 1'b0, {16'h0000, 1'b1, 1'b0, 1'b0, 1'b1}};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, {16'h0000, 1'b1, 1'b0, 1'b0, 1'b1}};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, {16'h0000, 1'b1, 1'b0, 1'b1, 1'b1}};
        vecs[7] = '{16'h1234, 16'h4321, 1'b0, {16'h5555, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[8] = '{16'h0000, 16'h0001, 1'b1, {16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0}};
        vecs[9] = '{16'h7FFF, 16'hFFFF, 1'b1, {16'h8000, 1'b0, 1'b1, 1'b1, 1'b0}};
        for (int k = 0; k < 5; k++) begin
            bp_a[k] = 16'($urandom);
            bp_b[k] = 16'($urandom);
            bp_s[k] = 1'($urandom_range(1, 0));
        end
        hold_pending = 1'b0;
        hold_val     = '0;

        // Reset
        rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_a = '0; i_b = '0;
        i_sub = 1'b0; i_ready = 1'b0;
        #12;
        check("reset_outputs", 32'({o_valid, got}), 32'd0);
        check("reset_ready", 32'(o_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", 32'(o_ready), 32'd1);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].exp);
        end
        @(posedge clk); #1;

        // Backpressure: 5 ops offered with the sink stalled
        i_ready = 1'b0;
        acc = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(posedge clk); #1;
            i_valid = (acc < 5);
            if (acc < 5) begin
                i_a = bp_a[acc]; i_b = bp_b[acc]; i_sub = bp_s[acc];
            end
            @(negedge clk);
            if (i_valid && o_ready) acc++;
        end
        check("bp_accepted", 32'(acc), 32'd3);
        check("bp_ready_low", 32'(o_ready), 32'd0);
        check("bp_valid_high", 32'(o_valid), 32'd1);
        check("bp_first_held", 32'(got), 32'(model(bp_a[0], bp_b[0], bp_s[0])));
        @(negedge clk);
        check("bp_first_stable", 32'(got), 32'(model(bp_a[0], bp_b[0], bp_s[0])));
        @(posedge clk); #1;
        i_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_drain_valid", 32'(o_valid), 32'd1);
            check("bp_drain_result", 32'(got), 32'(model(bp_a[k], bp_b[k], bp_s[k])));
            if (i_valid && o_ready) acc++;
            @(posedge clk); #1;
            i_valid = (acc < 5);
            if (acc < 5) begin
                i_a = bp_a[acc]; i_b = bp_b[acc]; i_sub = bp_s[acc];
            end
        end
        repeat (4) @(posedge clk);
        #1;

        // Flush with three ops in flight
        i_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            i_valid = 1'b1; i_a = bp_a[k]; i_b = bp_b[k]; i_sub = bp_s[k];
        end
        @(posedge clk); #1;
        i_valid = 1'b0; i_flush = 1'b1;
        @(negedge clk);
        check("flush_pre_valid", 32'(o_valid), 32'd1);
        check("flush_pre_full", 32'(o_ready), 32'd0);
        @(posedge clk); #1;
        i_flush = 1'b0;
        @(negedge clk);
        check("flush_valid_low", 32'(o_valid), 32'd0);
        check("flush_ready_high", 32'(o_ready), 32'd1);
        // Flush coinciding with an accepted input: the input must vanish
        @(posedge clk); #1;
        i_valid = 1'b1; i_flush = 1'b1; i_a = 16'h1234; i_b = 16'h0001; i_sub = 1'b0;
        @(negedge clk);
        check("flush_sim_ready", 32'(o_ready), 32'd1);
        @(posedge clk); #1;
        i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (o_valid) seen++;
        end
        check("flush_input_dropped", 32'(seen), 32'd0);

        // Asynchronous reset with results on the output
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            i_valid = 1'b1; i_a = 16'(16'h1111 + k); i_b = 16'h0001; i_sub = 1'b0;
        end
        @(posedge clk); #1;
        i_valid = 1'b0;
        #1;
        check("rst_mid_pre_valid", 32'(o_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", 32'({o_valid, got}), 32'd0);
        check("rst_mid_ready", 32'(o_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(vecs[0].a, vecs[0].b, vecs[0].sub, vecs[0].exp);

        // Random stream against the model; first 1000 ops are A-A
        @(posedge clk); #1;
        i_valid = 1'b0;
        exp_q.delete();
        hold_pending = 1'b0;
        @(negedge clk);
        for (int n = 0; n < 10000; n++) begin
            @(posedge clk); #1;
            if (n < 1000) begin
                i_valid = 1'b1;
                i_a     = 16'($urandom);
                i_b     = i_a;
                i_sub   = 1'b1;
                i_ready = 1'b1;
            end else begin
                i_valid = ($urandom_range(3, 0) != 0);
                i_a     = 16'($urandom);
                i_b     = 16'($urandom);
                i_sub   = 1'($urandom_range(1, 0));
                i_ready = ($urandom_range(9, 0) < 7);
            end
            @(negedge clk);
            sb_step();
        end
        @(posedge clk); #1;
        i_valid = 1'b0; i_ready = 1'b1;
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) begin
            @(negedge clk);
            sb_step();
            @(posedge clk); #1;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/math_addsub_brent_kung_pipe_016.md
Name: math_addsub_brent_kung_pipe_016

Overview:
- Pipelined 16-bit two's-complement add/subtract unit built on a Brent-Kung prefix carry network.
- Subtraction inverts operand B and injects carry-in = 1, so the same prefix tree serves both directions.
- Three register stages with a valid/ready handshake on each side.
- Sits in the math library as the sequential arithmetic front end for datapaths that need throughput of one operation per clock with backpressure.

Parameters:
- N, 16, operand width. The prefix tree is fixed for 16; elaboration errors out for any other value.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_flush  in  1  synchronous pipeline flush
- i_valid  in  1  input operation valid
- o_ready  out  1  unit can accept an input this cycle
- i_a  in  N  operand A
- i_b  in  N  operand B
- i_sub  in  1  1 = A-B, 0 = A+B
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts result
- o_sum  out  N  result
- o_carry  out  1  carry out of MSB (for subtract, 1 = no borrow)
- o_borrow  out  1  subtract only: ~carry; 0 in add mode
- o_ovf  out  1  signed overflow
- o_zero  out  1  result == 0

Behaviour:
- Single clock domain: one clock (i_clk) with asynchronous active-low reset i_rst_n.
- Reset value of every output is 0. o_ready is combinational and reads 1 once reset is released.
- Stage S1 register, loaded on input handshake:
  - bm = i_b ^ {N{i_sub}}; cin = i_sub.
  - p[N:0] = {a^bm, cin}; g[N:0] = {a&bm, cin}. Bit 0 is the carry-in position.
  - Register a[N-1], bm[N-1], i_sub and p,g.
- Stage S2 register: Brent-Kung up-sweep.
  - Pairwise black cells: 2:1 … 16:15 style spans.
  - Levels 2, 4 and 8: group G/P spans; G at positions 1, 3, 7, 15 resolved to bit 0.
  - Register the group G/P spans plus the S1 side data.
- Stage S3 register: down-sweep.
  - Gray cells fill carries 5, 9, 11, 13, then even positions 2…16.
  - sum[i] = p[i+1] ^ C[i], where C[i] = group G from bit i down to 0.
  - carry = C[N]. ovf = carry into MSB ^ carry out of MSB.
  - zero = ~|sum. borrow = i_sub & ~carry.
  - Register all of these to the outputs.
- Latency: exactly 3 cycles from input handshake to o_valid when there is no stall. Throughput: 1 operation per cycle.
- Handshake, per stage k with valid flag v_k:
  - Stage k advances when !v_k || ready_(k+1); ready_4 = i_ready.
  - o_ready = !v1 || advance2.
  - o_valid = v3.
  - Data is held stable while o_valid & !i_ready. No bubbles are inserted when the pipe is full and flowing.
- Backpressure:
  - With i_ready low, the pipe fills: three operations are held.
  - o_ready drops only when all three stages are valid.
  - Nothing is dropped or duplicated.
- Simultaneous i_valid & o_ready & i_flush: flush wins. All v_k clear next cycle and the input is not captured. Data registers keep stale values, which are don't-care while invalid.
- Reset mid-operation: all valids clear immediately and asynchronously; outputs return to 0.
- Wrap-around: modulo 2^N. 0xFFFF+1 gives sum 0, carry 1.

Decomposition:
- Package math_adder_pkg:
  - N16 constant.
  - typedef pg_t (struct: g, p).
  - Function bk_black(pg_hi, pg_lo) returning pg_t.
  - Function bk_gray(pg_hi, g_lo) returning the g bit.
- One sub-module, math_addsub_pipe_stage: a generic valid/ready register slice parameterised by payload width, instantiated three times.
- Prefix cells are package functions, not separate modules.

Test Plan:
- Subtract, no borrow: a=0x0005, b=0x0003, sub=1 -> after 3 cycles sum=0x0002, carry=1, borrow=0, ovf=0, zero=0.
- Subtract with borrow: a=0x0003, b=0x0005, sub=1 -> sum=0xFFFE, borrow=1, carry=0, ovf=0.
- Signed overflow:
  - Subtract: a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1, carry=1.
  - Add: a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, ovf=1, carry=0.
- Add wrap / zero: a=0xFFFF, b=0x0001, sub=0 -> sum=0x0000, carry=1, zero=1, borrow=0. Also A-A for 1000 random A -> zero=1, carry=1.
- Backpressure:
  - Stream 5 ops with i_ready=0 -> o_ready falls after 3 accepted; o_valid stays high with the first result stable.
  - Then i_ready=1 -> all 5 results appear in order on consecutive cycles.
- Flush and reset:
  - i_flush with 3 ops in flight -> o_valid=0 next cycle.
  - i_rst_n low mid-stream -> all outputs 0 asynchronously; first op after release appears 3 cycles later.
  - Random 10k ops, random sub/ready vs a reference model -> no mismatch.
